// File: rtl/hf_granule_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hf_pkg
//  Description : Shared types and constants for the Huffman granule writer
//                and the per-table pair decoders.
//  Revision    : 1.0 - initial release
// ============================================================================
package hf_pkg;

    localparam int N_SAMPLES      = 576;
    localparam int MAX_BIG_VALUES = 288;
    localparam int SAMPLE_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIG  = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } hf_wr_state_t;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] x;
        logic signed [SAMPLE_W-1:0] y;
    } hf_pair_t;

    // Region lookup: ts0 below region 1, ts1 below region 2, ts2 beyond.
    function automatic logic [4:0] hf_table_for(
        input logic [10:0] idx,
        input logic [9:0]  r1,
        input logic [9:0]  r2,
        input logic [14:0] ts
    );
        if (idx < {1'b0, r1}) begin
            return ts[4:0];
        end else if (idx < {1'b0, r2}) begin
            return ts[9:5];
        end else begin
            return ts[14:10];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/hf_granule_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : hf_granule_writer_if
//  Description : Side-info, decoded-pair handshake and sample-RAM write bus
//                of the Huffman granule writer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hf_granule_writer_if;
    import hf_pkg::*;

    logic                       start;
    logic [8:0]                 big_values;
    logic [9:0]                 region1_start;
    logic [9:0]                 region2_start;
    logic [14:0]                table_sel;
    logic                       pair_valid;
    logic signed [SAMPLE_W-1:0] x_val;
    logic signed [SAMPLE_W-1:0] y_val;
    logic                       hf_ready;
    logic [4:0]                 active_table;
    logic                       wr_en;
    logic [9:0]                 wr_addr;
    logic signed [SAMPLE_W-1:0] wr_data;
    logic                       done;
    logic                       overflow;

    // Upstream side: side-info and decoder output, consumes status
    modport master (
        output start, big_values, region1_start, region2_start, table_sel,
        output pair_valid, x_val, y_val,
        input  hf_ready, active_table, wr_en, wr_addr, wr_data, done, overflow
    );

    // Writer side
    modport slave (
        input  start, big_values, region1_start, region2_start, table_sel,
        input  pair_valid, x_val, y_val,
        output hf_ready, active_table, wr_en, wr_addr, wr_data, done, overflow
    );
endinterface
`default_nettype wire

// File: rtl/hf_granule_writer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : hf_pair_fifo
//  Description : Small synchronous FIFO of decoded (x,y) pairs.
//                DEPTH must be a power of two, at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module hf_pair_fifo
    import hf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  hf_pair_t                   i_data,
    input  logic                       i_pop,
    output hf_pair_t                   o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int c_AW = $clog2(DEPTH);

    hf_pair_t              r_mem [DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_AW:0]         r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;
    assign o_full    = (r_count == (c_AW + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/hf_granule_writer.sv
`default_nettype none
// ============================================================================
//  Module      : hf_granule_writer
//  Description : Selects the Huffman table per region, buffers decoded pairs
//                and writes them as sequential samples into the granule
//                sample RAM, then zero-fills the rest of the granule.
//  Revision    : 1.0 - initial release
// ============================================================================
module hf_granule_writer #(
    parameter int N_SAMPLES  = hf_pkg::N_SAMPLES,
    parameter int FIFO_DEPTH = 2,
    parameter int SAMPLE_W   = hf_pkg::SAMPLE_W
) (
    input  logic               clk,
    input  logic               rst,
    hf_granule_writer_if.slave bus
);
    localparam int         c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [9:0] c_LAST_ADDR = 10'(N_SAMPLES - 1);
    localparam logic [8:0] c_MAX_BV    = 9'(hf_pkg::MAX_BIG_VALUES);

    hf_pkg::hf_wr_state_t       r_state;
    hf_pkg::hf_wr_state_t       w_state_nx;

    logic [8:0]                 r_bv, w_bv_nx, w_bv_clamped;
    logic [8:0]                 r_acc, w_acc_nx;
    logic [9:0]                 r_r1, r_r2, w_r1_nx, w_r2_nx;
    logic [14:0]                r_ts, w_ts_nx;
    logic [9:0]                 r_addr;
    logic                       r_phase;
    logic signed [SAMPLE_W-1:0] r_y;
    logic                       r_hf_ready;
    logic [4:0]                 r_active_table;
    logic                       r_overflow;

    logic                       w_start_ok;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_wr_en;
    logic [9:0]                 w_wr_addr;
    logic signed [SAMPLE_W-1:0] w_wr_data;
    logic                       w_ready_nx;
    int                         w_count_nx;

    hf_pkg::hf_pair_t           w_head;
    hf_pkg::hf_pair_t           w_in_pair;
    logic [c_CNT_W-1:0]         w_count;
    logic                       w_full;
    logic                       w_empty;

    // Side-info as it will look after this edge
    assign w_start_ok   = (r_state == hf_pkg::ST_IDLE) && bus.start;
    assign w_bv_clamped = (bus.big_values > c_MAX_BV) ? c_MAX_BV : bus.big_values;
    assign w_bv_nx      = w_start_ok ? w_bv_clamped       : r_bv;
    assign w_r1_nx      = w_start_ok ? bus.region1_start  : r_r1;
    assign w_r2_nx      = w_start_ok ? bus.region2_start  : r_r2;
    assign w_ts_nx      = w_start_ok ? bus.table_sel      : r_ts;

    // Accepted pairs only arrive in BIG while the registered ready is high
    assign w_push    = (r_state == hf_pkg::ST_BIG) && bus.pair_valid && r_hf_ready && !w_full;
    assign w_acc_nx  = w_start_ok ? 9'd0 : (w_push ? r_acc + 9'd1 : r_acc);
    assign w_in_pair = '{x: bus.x_val, y: bus.y_val};

    hf_pair_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_in_pair),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= hf_pkg::ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state and RAM write port: x is popped straight from the FIFO head,
    // y follows from the holding register on the next cycle
    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        w_wr_en    = 1'b0;
        w_wr_addr  = '0;
        w_wr_data  = '0;
        case (r_state)
            hf_pkg::ST_IDLE: begin
                if (bus.start) begin
                    w_state_nx = (w_bv_clamped != 9'd0) ? hf_pkg::ST_BIG : hf_pkg::ST_FILL;
                end
            end
            hf_pkg::ST_BIG: begin
                if (r_phase) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_addr;
                    w_wr_data = r_y;
                end else if (!w_empty) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_addr;
                    w_wr_data = w_head.x;
                    w_pop     = 1'b1;
                end else if (r_acc == r_bv) begin
                    w_state_nx = hf_pkg::ST_FILL;
                end
            end
            hf_pkg::ST_FILL: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_addr;
                if (r_addr == c_LAST_ADDR) begin
                    w_state_nx = hf_pkg::ST_DONE;
                end
            end
            hf_pkg::ST_DONE: begin
                w_state_nx = hf_pkg::ST_IDLE;
            end
            default: begin
                w_state_nx = hf_pkg::ST_IDLE;
            end
        endcase
    end

    // Ready for the next cycle, from post-edge occupancy and pair count
    always_comb begin
        w_count_nx = int'(w_count) + (w_push ? 1 : 0) - (w_pop ? 1 : 0);
        w_ready_nx = (w_state_nx == hf_pkg::ST_BIG) && (w_count_nx < FIFO_DEPTH) && (w_acc_nx < w_bv_nx);
    end

    // Granule side-info latch and accepted-pair counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bv  <= '0;
            r_r1  <= '0;
            r_r2  <= '0;
            r_ts  <= '0;
            r_acc <= '0;
        end else begin
            r_bv  <= w_bv_nx;
            r_r1  <= w_r1_nx;
            r_r2  <= w_r2_nx;
            r_ts  <= w_ts_nx;
            r_acc <= w_acc_nx;
        end
    end

    // Write address counter and x/y phase of the pair writer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_phase <= 1'b0;
            r_y     <= '0;
        end else if (w_start_ok) begin
            r_addr  <= '0;
            r_phase <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_addr <= r_addr + 10'd1;
            end
            if (r_phase) begin
                r_phase <= 1'b0;
            end else if (w_pop) begin
                r_phase <= 1'b1;
                r_y     <= w_head.y;
            end
        end
    end

    // Registered handshake, table index and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hf_ready     <= 1'b0;
            r_active_table <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_hf_ready <= w_ready_nx;
            if (w_start_ok || w_push) begin
                r_active_table <= hf_pkg::hf_table_for({1'b0, w_acc_nx, 1'b0}, w_r1_nx, w_r2_nx, w_ts_nx);
            end
            if (w_start_ok) begin
                r_overflow <= 1'b0;
            end else if (bus.pair_valid && !r_hf_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // A reset cycle must never leak a RAM write
    assign bus.wr_en        = w_wr_en && !rst;
    assign bus.wr_addr      = w_wr_addr;
    assign bus.wr_data      = w_wr_data;
    assign bus.hf_ready     = r_hf_ready;
    assign bus.active_table = r_active_table;
    assign bus.done         = (r_state == hf_pkg::ST_DONE);
    assign bus.overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_hf_granule_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hf_granule_writer
//  Description : Scoreboard bench for hf_granule_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hf_granule_writer;
    import hf_pkg::*;

    typedef struct {
        logic [9:0]        a;
        logic signed [15:0] d;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_writes;
    bit   stalled;
    exp_t sb[$];
    int   px[16];
    int   py[16];
    int   exp_tab[16];

    hf_granule_writer_if bus();

    hf_granule_writer #(
        .N_SAMPLES  (576),
        .FIFO_DEPTH (2),
        .SAMPLE_W   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    function automatic void push_exp(input int a, input int d);
        exp_t e;
        e.a = 10'(a);
        e.d = 16'(d);
        sb.push_back(e);
    endfunction

    function automatic void push_granule(input int bv);
        for (int k = 0; k < bv; k++) begin
            push_exp(2 * k, px[k]);
            push_exp(2 * k + 1, py[k]);
        end
        for (int a = 2 * bv; a < 576; a++) begin
            push_exp(a, 0);
        end
    endfunction

    // Monitor: every RAM write is popped against the expected queue
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.wr_en === 1'b1) begin
            n_writes++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0d, required no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                e = sb.pop_front();
                if (bus.wr_addr !== e.a || bus.wr_data !== e.d) begin
                    n_fail++;
                    $display("FAIL write: got addr %0d data %0d, required addr %0d data %0d",
                             bus.wr_addr, bus.wr_data, e.a, e.d);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the first cycle after start
    task automatic do_start(input int bv, input int r1, input int r2, input logic [14:0] ts);
        bus.start         = 1'b1;
        bus.big_values    = 9'(bv);
        bus.region1_start = 10'(r1);
        bus.region2_start = 10'(r2);
        bus.table_sel     = ts;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Offers pair k only while hf_ready is high; gap idle cycles between pairs
    task automatic feed(input int n, input int gap, input bit chk_tab);
        int k;
        int idle;
        int guard;
        k = 0; idle = 0; guard = 0;
        while (k < n && guard < 500) begin
            if (k > 0 && bus.hf_ready !== 1'b1) stalled = 1'b1;
            if (idle == 0 && bus.hf_ready === 1'b1) begin
                bus.pair_valid = 1'b1;
                bus.x_val      = 16'(px[k]);
                bus.y_val      = 16'(py[k]);
                if (chk_tab) check($sformatf("active_table_pair%0d", k), bus.active_table, exp_tab[k]);
                k++;
                idle = gap;
            end else begin
                bus.pair_valid = 1'b0;
                if (idle > 0) idle--;
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.pair_valid = 1'b0;
        if (k < n) check("feed_timeout", k, n);
    endtask

    // Cycle index i=1 is the current cycle; optionally forces pair_valid at cycle inj
    task automatic wait_done(input int inj, output int cyc);
        int pulses;
        pulses = 0;
        cyc    = 0;
        for (int i = 1; i <= 1500; i++) begin
            if (inj >= 0) bus.pair_valid = (i == inj);
            if (bus.done === 1'b1) begin
                pulses++;
                if (cyc == 0) cyc = i;
            end
            if (pulses > 0 && bus.done !== 1'b1) break;
            @(posedge clk); #1;
        end
        bus.pair_valid = 1'b0;
        check("done_pulses", pulses, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int cyc;
        int base;
        n_checks = 0; n_fail = 0; n_writes = 0; stalled = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0; bus.big_values = '0; bus.region1_start = '0;
        bus.region2_start = '0; bus.table_sel = '0; bus.pair_valid = 1'b0;
        bus.x_val = '0; bus.y_val = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_hf_ready", bus.hf_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_active_table", bus.active_table, 0);
        check("rst_done", bus.done, 0);
        check("rst_overflow", bus.overflow, 0);
        @(posedge clk); #1;

        // Three spaced pairs with signed values
        px[0] = 1;    py[0] = -2;
        px[1] = 0;    py[1] = 15;
        px[2] = -300; py[2] = 7;
        push_granule(3);
        do_start(3, 576, 576, 15'd0);
        feed(3, 3, 1'b0);
        wait_done(-1, cyc);
        check("t1_pending", sb.size(), 0);
        check("t1_overflow", bus.overflow, 0);

        // Back-to-back offers: FIFO fills and ready throttles
        for (int k = 0; k < 10; k++) begin
            px[k] = 100 + k;
            py[k] = -1 - k;
        end
        push_granule(10);
        stalled = 1'b0;
        base = n_writes;
        do_start(10, 576, 576, 15'd0);
        feed(10, 0, 1'b0);
        check("t2_stall_seen", stalled, 1);
        wait_done(-1, cyc);
        check("t2_total_writes", n_writes - base, 576);
        check("t2_pending", sb.size(), 0);
        check("t2_overflow", bus.overflow, 0);

        // Region table select: ts2=7, ts1=13, ts0=29
        for (int k = 0; k < 6; k++) begin
            px[k] = 10 * k + 3;
            py[k] = -(10 * k + 4);
        end
        exp_tab[0] = 29; exp_tab[1] = 29;
        exp_tab[2] = 13; exp_tab[3] = 13;
        exp_tab[4] = 7;  exp_tab[5] = 7;
        push_granule(6);
        do_start(6, 4, 8, {5'd7, 5'd13, 5'd29});
        check("t3_table_at_start", bus.active_table, 29);
        feed(6, 0, 1'b1);
        wait_done(-1, cyc);
        check("t3_pending", sb.size(), 0);

        // Empty big_values region, with a forced pair during the fill
        push_granule(0);
        do_start(0, 0, 0, 15'd0);
        check("t4_hf_ready_fill", bus.hf_ready, 0);
        wait_done(10, cyc);
        check("t4_done_latency", cyc, 577);
        check("t4_pending", sb.size(), 0);
        check("t4_overflow_set", bus.overflow, 1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_overflow_sticky", bus.overflow, 1);

        // Reset in the middle of a fill after 50 writes
        for (int a = 0; a < 50; a++) push_exp(a, 0);
        base = n_writes;
        do_start(0, 0, 0, 15'd0);
        check("t5_overflow_cleared", bus.overflow, 0);
        for (int i = 0; i < 200 && (n_writes - base) < 50; i++) begin
            @(posedge clk); #1;
        end
        check("t5_writes_before_rst", n_writes - base, 50);
        rst = 1'b1;
        @(negedge clk);
        check("t5_wr_en_in_rst", bus.wr_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_wr_en_after", bus.wr_en, 0);
        check("t5_hf_ready_after", bus.hf_ready, 0);
        check("t5_done_after", bus.done, 0);
        repeat (5) @(posedge clk);
        #1;
        check("t5_pending", sb.size(), 0);

        // Fresh granule after the reset starts again at address 0
        px[0] = 5; py[0] = -5;
        push_granule(1);
        do_start(1, 576, 576, 15'd0);
        feed(1, 0, 1'b0);
        wait_done(-1, cyc);
        check("t6_pending", sb.size(), 0);
        check("t6_overflow", bus.overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
